tt_um_hoene_led_update_ctrl: RTL and testbench

- Sequences updates of the LED PWM colour registers from the 32-bit word delivered by the serial-to-parallel stage on its store strobe.
- Double-buffers each received word and commits it only at a PWM frame boundary, so no partial-period glitches occur.
- Supports immediate set, linear fade and blank commands.
- Sits between the protocol serial-to-parallel stage and the LED PWM block, and drives the red, green and blue 10-bit duty registers.

---
 rtl/tt_um_hoene_led_pkg.sv | 37 +++
 rtl/tt_um_hoene_led_channel_stepper.sv | 34 +++
 rtl/tt_um_hoene_led_update_ctrl.sv | 160 ++++++++++++++++
 tb/tb_tt_um_hoene_led_update_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_hoene_led_pkg.sv
// Shared definitions for the LED update controller: command encodings,
// input word field positions, controller states and channel width.
package tt_um_hoene_led_pkg;

    localparam int CW = 10;

    localparam int CMD_HI = 31;
    localparam int CMD_LO = 30;
    localparam int RED_HI = 29;
    localparam int RED_LO = 20;
    localparam int GRN_HI = 19;
    localparam int GRN_LO = 10;
    localparam int BLU_HI = 9;
    localparam int BLU_LO = 0;

    typedef enum logic [1:0] {
        CMD_SET   = 2'b00,
        CMD_FADE  = 2'b01,
        CMD_BLANK = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_e;

    // Unsigned distance between two channel values; never wraps.
    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

endpackage

// File: rtl/tt_um_hoene_led_channel_stepper.sv
// One fade step for a single colour channel: moves cur toward tgt by STEP,
// snapping onto tgt when it is within one step so the value never overshoots.
module tt_um_hoene_led_channel_stepper
    import tt_um_hoene_led_pkg::*;
#(
    parameter int STEP = 16
) (
    input  logic [CW-1:0] i_cur,
    input  logic [CW-1:0] i_tgt,
    output logic [CW-1:0] o_next,
    output logic          o_at_target
);

    localparam logic [CW-1:0] STEP_V = STEP[CW-1:0];

    logic [CW-1:0] w_diff;

    assign w_diff = abs_diff(i_cur, i_tgt);

    // Saturating step toward the target.
    always_comb begin
        o_next      = i_cur;
        o_at_target = 1'b0;
        if (w_diff <= STEP_V) begin
            o_next      = i_tgt;
            o_at_target = 1'b1;
        end else if (i_cur < i_tgt) begin
            o_next = i_cur + STEP_V;
        end else begin
            o_next = i_cur - STEP_V;
        end
    end

endmodule

// File: rtl/tt_um_hoene_led_update_ctrl.sv
// LED colour update controller: double-buffers received words and applies
// SET / FADE / BLANK commands to the PWM duty registers at frame boundaries.
module tt_um_hoene_led_update_ctrl
    import tt_um_hoene_led_pkg::*;
#(
    parameter int STEP = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          store,
    input  logic [31:0]   in_data,
    input  logic          frame_tick,
    output logic [CW-1:0] data_red,
    output logic [CW-1:0] data_green,
    output logic [CW-1:0] data_blue,
    output logic          busy,
    output logic          overrun,
    output logic          cmd_error,
    output logic          fade_done
);

    logic [31:0]   r_shadow,  w_shadow_n;
    logic          r_pending, w_pending_n;
    state_e        r_state,   w_state_n;
    logic [CW-1:0] r_red,     w_red_n;
    logic [CW-1:0] r_green,   w_green_n;
    logic [CW-1:0] r_blue,    w_blue_n;
    logic [CW-1:0] r_tgt_red, w_tgt_red_n;
    logic [CW-1:0] r_tgt_grn, w_tgt_grn_n;
    logic [CW-1:0] r_tgt_blu, w_tgt_blu_n;
    logic          r_busy;
    logic          r_overrun,   w_overrun_n;
    logic          r_cmd_error, w_cmd_error_n;
    logic          r_fade_done, w_fade_done_n;

    cmd_e          w_cmd;
    logic          w_commit;
    logic [CW-1:0] w_step_red, w_step_grn, w_step_blu;
    logic          w_at_red, w_at_grn, w_at_blu;

    assign w_cmd    = cmd_e'(r_shadow[CMD_HI:CMD_LO]);
    assign w_commit = frame_tick & r_pending;

    tt_um_hoene_led_channel_stepper #(.STEP(STEP)) u_step_red (
        .i_cur(r_red), .i_tgt(r_tgt_red), .o_next(w_step_red), .o_at_target(w_at_red)
    );
    tt_um_hoene_led_channel_stepper #(.STEP(STEP)) u_step_grn (
        .i_cur(r_green), .i_tgt(r_tgt_grn), .o_next(w_step_grn), .o_at_target(w_at_grn)
    );
    tt_um_hoene_led_channel_stepper #(.STEP(STEP)) u_step_blu (
        .i_cur(r_blue), .i_tgt(r_tgt_blu), .o_next(w_step_blu), .o_at_target(w_at_blu)
    );

    // Next-state: a pending word always wins over a fade step at a tick.
    always_comb begin
        w_shadow_n    = r_shadow;
        w_pending_n   = r_pending;
        w_state_n     = r_state;
        w_red_n       = r_red;
        w_green_n     = r_green;
        w_blue_n      = r_blue;
        w_tgt_red_n   = r_tgt_red;
        w_tgt_grn_n   = r_tgt_grn;
        w_tgt_blu_n   = r_tgt_blu;
        w_overrun_n   = 1'b0;
        w_cmd_error_n = 1'b0;
        w_fade_done_n = 1'b0;

        if (w_commit) begin
            case (w_cmd)
                CMD_SET: begin
                    w_red_n   = r_shadow[RED_HI:RED_LO];
                    w_green_n = r_shadow[GRN_HI:GRN_LO];
                    w_blue_n  = r_shadow[BLU_HI:BLU_LO];
                    w_state_n = IDLE;
                end
                CMD_FADE: begin
                    w_tgt_red_n = r_shadow[RED_HI:RED_LO];
                    w_tgt_grn_n = r_shadow[GRN_HI:GRN_LO];
                    w_tgt_blu_n = r_shadow[BLU_HI:BLU_LO];
                    w_state_n   = FADE;
                end
                CMD_BLANK: begin
                    w_red_n   = {CW{1'b0}};
                    w_green_n = {CW{1'b0}};
                    w_blue_n  = {CW{1'b0}};
                    w_state_n = IDLE;
                end
                default: begin
                    w_cmd_error_n = 1'b1;
                end
            endcase
        end else if (frame_tick && (r_state == FADE)) begin
            w_red_n   = w_step_red;
            w_green_n = w_step_grn;
            w_blue_n  = w_step_blu;
            if (w_at_red && w_at_grn && w_at_blu) begin
                w_state_n     = IDLE;
                w_fade_done_n = 1'b1;
            end else begin
                w_state_n = FADE;
            end
        end else begin
            w_state_n = r_state;
        end

        // A store coinciding with a tick is not an overrun: the tick frees the slot.
        if (store) begin
            w_shadow_n  = in_data;
            w_pending_n = 1'b1;
            w_overrun_n = r_pending & ~frame_tick;
        end else if (w_commit) begin
            w_pending_n = 1'b0;
        end else begin
            w_pending_n = r_pending;
        end
    end

    // State and output registers; busy is a registered copy of pending|fading.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= 32'd0;
            r_pending   <= 1'b0;
            r_state     <= IDLE;
            r_red       <= {CW{1'b0}};
            r_green     <= {CW{1'b0}};
            r_blue      <= {CW{1'b0}};
            r_tgt_red   <= {CW{1'b0}};
            r_tgt_grn   <= {CW{1'b0}};
            r_tgt_blu   <= {CW{1'b0}};
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_cmd_error <= 1'b0;
            r_fade_done <= 1'b0;
        end else begin
            r_shadow    <= w_shadow_n;
            r_pending   <= w_pending_n;
            r_state     <= w_state_n;
            r_red       <= w_red_n;
            r_green     <= w_green_n;
            r_blue      <= w_blue_n;
            r_tgt_red   <= w_tgt_red_n;
            r_tgt_grn   <= w_tgt_grn_n;
            r_tgt_blu   <= w_tgt_blu_n;
            r_busy      <= r_pending | (r_state == FADE);
            r_overrun   <= w_overrun_n;
            r_cmd_error <= w_cmd_error_n;
            r_fade_done <= w_fade_done_n;
        end
    end

    assign data_red   = r_red;
    assign data_green = r_green;
    assign data_blue  = r_blue;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign cmd_error  = r_cmd_error;
    assign fade_done  = r_fade_done;

endmodule

// File: tb/tb_tt_um_hoene_led_update_ctrl.sv
// Directed bench for the LED update controller: an abstract per-cycle model
// is compared against the DUT every cycle, plus hand-computed spot values.
module tb_tt_um_hoene_led_update_ctrl;

    localparam int STEP = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        store;
    logic [31:0] in_data;
    logic        frame_tick;
    logic [9:0]  data_red, data_green, data_blue;
    logic        busy, overrun, cmd_error, fade_done;

    always #5 clk = ~clk;

    tt_um_hoene_led_update_ctrl #(.STEP(STEP)) dut (
        .clk(clk), .rst(rst), .store(store), .in_data(in_data), .frame_tick(frame_tick),
        .data_red(data_red), .data_green(data_green), .data_blue(data_blue),
        .busy(busy), .overrun(overrun), .cmd_error(cmd_error), .fade_done(fade_done)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wd(input int cmd, input int r, input int g, input int b);
        return {2'(cmd), 10'(r), 10'(g), 10'(b)};
    endfunction

    function automatic int toward(input int c, input int t);
        int d;
        d = t - c;
        if (d <= STEP && d >= -STEP) return t;
        return (d > 0) ? c + STEP : c - STEP;
    endfunction

    // Behavioural model: colour as three integers, one optional pending word.
    int          m_cur[3];
    int          m_tgt[3];
    bit          m_pend, m_fade, m_busy, m_ovr, m_err, m_done;
    logic [31:0] m_shadow;

    always @(posedge clk) begin : model
        int  cmd;
        bit  all_eq;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin m_cur[i] = 0; m_tgt[i] = 0; end
            m_pend = 0; m_fade = 0; m_busy = 0; m_ovr = 0; m_err = 0; m_done = 0;
            m_shadow = 32'd0;
        end else begin
            m_busy = m_pend || m_fade;
            m_ovr  = store && m_pend && !frame_tick;
            m_err  = 0;
            m_done = 0;
            if (frame_tick && m_pend) begin
                cmd = int'(m_shadow[31:30]);
                if (cmd == 0) begin
                    for (int i = 0; i < 3; i++) m_cur[i] = int'(m_shadow[29-10*i -: 10]);
                    m_fade = 0;
                end else if (cmd == 1) begin
                    for (int i = 0; i < 3; i++) m_tgt[i] = int'(m_shadow[29-10*i -: 10]);
                    m_fade = 1;
                end else if (cmd == 2) begin
                    for (int i = 0; i < 3; i++) m_cur[i] = 0;
                    m_fade = 0;
                end else begin
                    m_err = 1;
                end
                m_pend = 0;
            end else if (frame_tick && m_fade) begin
                all_eq = 1;
                for (int i = 0; i < 3; i++) begin
                    m_cur[i] = toward(m_cur[i], m_tgt[i]);
                    if (m_cur[i] != m_tgt[i]) all_eq = 0;
                end
                if (all_eq) begin m_fade = 0; m_done = 1; end
            end
            if (store) begin m_shadow = in_data; m_pend = 1; end
        end
    end

    // Compare every output against the model on the inactive edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_red",     {22'd0, data_red},   m_cur[0]);
            chk("m_green",   {22'd0, data_green}, m_cur[1]);
            chk("m_blue",    {22'd0, data_blue},  m_cur[2]);
            chk("m_busy",    {31'd0, busy},       {31'd0, m_busy});
            chk("m_overrun", {31'd0, overrun},    {31'd0, m_ovr});
            chk("m_cmd_err", {31'd0, cmd_error},  {31'd0, m_err});
            chk("m_done",    {31'd0, fade_done},  {31'd0, m_done});
        end
    end

    task automatic cyc(input bit r, input bit s, input logic [31:0] d, input bit t);
        rst = r; store = s; in_data = d; frame_tick = t;
        @(negedge clk);
        rst = 1'b0; store = 1'b0; in_data = 32'd0; frame_tick = 1'b0;
    endtask

    task automatic rgb(input string n, input int r, input int g, input int b);
        chk({n, "_r"}, {22'd0, data_red},   r);
        chk({n, "_g"}, {22'd0, data_green}, g);
        chk({n, "_b"}, {22'd0, data_blue},  b);
    endtask

    initial begin
        rst = 1'b1; store = 1'b0; in_data = 32'd0; frame_tick = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_en = 1'b1;
        rgb("reset", 0, 0, 0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // SET 1023/512/1
        cyc(0, 1, 32'h3FF80001, 0);
        cyc(0, 0, 0, 1);
        rgb("set", 1023, 512, 1);
        cyc(0, 0, 0, 0);
        chk("set_busy", {31'd0, busy}, 32'd0);

        // Fade up 0/0/0 -> 40/16/0
        cyc(0, 1, wd(2, 0, 0, 0), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, wd(1, 40, 16, 0), 0);
        cyc(0, 0, 0, 1);
        rgb("fade_commit", 0, 0, 0);
        cyc(0, 0, 0, 1);
        rgb("fade_t1", 16, 16, 0);
        cyc(0, 0, 0, 1);
        rgb("fade_t2", 32, 16, 0);
        cyc(0, 0, 0, 1);
        rgb("fade_t3", 40, 16, 0);
        chk("fade_done", {31'd0, fade_done}, 32'd1);
        chk("fade_busy_hold", {31'd0, busy}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("fade_busy_drop", {31'd0, busy}, 32'd0);
        chk("fade_done_once", {31'd0, fade_done}, 32'd0);

        // Overrun: last word wins
        cyc(0, 1, wd(0, 100, 100, 100), 0);
        cyc(0, 1, wd(0, 5, 6, 7), 0);
        chk("overrun_pulse", {31'd0, overrun}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("overrun_once", {31'd0, overrun}, 32'd0);
        cyc(0, 0, 0, 1);
        rgb("overrun_val", 5, 6, 7);

        // Fade into the top of the range
        cyc(0, 1, wd(0, 1000, 1010, 5), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, wd(1, 1023, 1023, 0), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        rgb("top_t1", 1016, 1023, 0);
        cyc(0, 0, 0, 1);
        rgb("top_t2", 1023, 1023, 0);
        chk("top_done", {31'd0, fade_done}, 32'd1);

        // Fade abort by BLANK
        cyc(0, 1, wd(2, 0, 0, 0), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, wd(1, 1000, 0, 0), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        rgb("abort_mid", 32, 0, 0);
        cyc(0, 1, wd(2, 0, 0, 0), 0);
        cyc(0, 0, 0, 1);
        rgb("abort", 0, 0, 0);
        chk("abort_no_done", {31'd0, fade_done}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        cyc(0, 0, 0, 1);
        rgb("abort_idle_tick", 0, 0, 0);

        // Simultaneous store and tick
        cyc(0, 1, wd(0, 10, 10, 10), 0);
        cyc(0, 1, wd(0, 20, 20, 20), 1);
        rgb("simul_old", 10, 10, 10);
        chk("simul_no_ovr", {31'd0, overrun}, 32'd0);
        cyc(0, 0, 0, 1);
        rgb("simul_new", 20, 20, 20);
        cyc(0, 1, wd(0, 30, 30, 30), 1);
        rgb("simul_wait", 20, 20, 20);
        cyc(0, 0, 0, 1);
        rgb("simul_wait_done", 30, 30, 30);

        // Fade whose target equals the start
        cyc(0, 1, wd(1, 30, 30, 30), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("eq_fade_done", {31'd0, fade_done}, 32'd1);
        rgb("eq_fade", 30, 30, 30);

        // Reserved command
        cyc(0, 1, wd(3, 1, 2, 3), 0);
        cyc(0, 0, 0, 1);
        rgb("rsvd_hold", 30, 30, 30);
        chk("rsvd_err", {31'd0, cmd_error}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("rsvd_err_once", {31'd0, cmd_error}, 32'd0);

        // Reset mid-fade
        cyc(0, 1, wd(1, 500, 500, 500), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        rgb("rst_mid", 46, 46, 46);
        cyc(1, 0, 0, 0);
        rgb("rst_fade", 0, 0, 0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        rgb("rst_after", 0, 0, 0);
        chk("rst_after_busy", {31'd0, busy}, 32'd0);

        cyc(0, 0, 0, 0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
